pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_ctrl_out_cnt.sv | 58 +++++
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the five-stage pipeline controller: stage indices,
// FSM encodings and the outstanding-request limit.
package pipe_pkg;

    localparam int MAX_OUT_DEF = 3;
    localparam int NUM_STAGES  = 5;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Counter width able to hold 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_out_cnt.sv
// Saturating up/down outstanding-request counter with a sticky error flag
// raised on overflow past MAX_OUT or a response with nothing outstanding.
module out_cnt
    import pipe_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = cnt_width(MAX_OUT)
) (
    input  logic             clk,
    input  logic             i_resetn,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_next,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_err;
    logic             w_err_next;

    // A request and a response in the same cycle cancel, even at the limits.
    always_comb begin
        w_cnt_next = r_cnt;
        w_err_next = r_err;
        if (i_inc && !i_dec) begin
            if (r_cnt == CNT_MAX) begin
                w_err_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end else if (!i_inc && i_dec) begin
            if (r_cnt == '0) begin
                w_err_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_err <= w_err_next;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_cnt_next;
    assign o_err      = r_err;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline handshake controller with exception/ertn flush and a
// drain phase that discards bus responses belonging to flushed requests.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    localparam int CNT_W  = cnt_width(MAX_OUT)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] ready_go,
    input  logic       wb_ex,
    input  logic       wb_ertn,
    input  logic       inst_req_fire,
    input  logic       inst_resp,
    input  logic       data_req_fire,
    input  logic       data_resp,
    output logic [4:0] stage_valid,
    output logic [4:0] allowin,
    output logic [3:0] load_en,
    output logic       flush,
    output logic       fetch_en,
    output logic       drop_resp,
    output logic [1:0] state,
    output logic       ovf_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [NUM_STAGES-1:0] r_stage_valid;
    logic [NUM_STAGES-1:0] w_sv_next;
    logic [NUM_STAGES-1:0] w_allowin;
    logic [3:0]            w_load;
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_flush;
    logic                  w_fetch_en;
    logic [CNT_W-1:0]      w_inst_cnt;
    logic [CNT_W-1:0]      w_inst_cnt_next;
    logic [CNT_W-1:0]      w_data_cnt;
    logic [CNT_W-1:0]      w_data_cnt_next;
    logic                  w_inst_err;
    logic                  w_data_err;

    // Backpressure ripples from WB (always accepting) toward IF.
    always_comb begin
        w_allowin         = '0;
        w_allowin[STG_WB] = 1'b1;
        for (int k = STG_WB - 1; k >= 0; k--) begin
            w_allowin[k] = !r_stage_valid[k] | (ready_go[k] & w_allowin[k+1]);
        end
    end

    assign w_flush    = (r_state == ST_RUN) & r_stage_valid[STG_WB] & (wb_ex | wb_ertn);
    assign w_fetch_en = (r_state == ST_RUN) & (w_inst_cnt < CNT_MAX) & !w_flush;

    assign w_sv_next[STG_IF] = w_flush ? 1'b0 :
                               (w_allowin[STG_IF] ? (w_fetch_en & inst_req_fire)
                                                  : r_stage_valid[STG_IF]);

    generate
        for (genvar gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_stage
            assign w_load[gi] = r_stage_valid[gi] & ready_go[gi] & w_allowin[gi+1] & !w_flush;
            assign w_sv_next[gi+1] = w_flush ? 1'b0 :
                                     (w_allowin[gi+1] ? (r_stage_valid[gi] & ready_go[gi])
                                                      : r_stage_valid[gi+1]);
        end
    endgenerate

    // FLUSH looks at post-update counts so a response in the flush cycle counts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_flush) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((w_inst_cnt_next != '0) || (w_data_cnt_next != '0)) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((w_inst_cnt == '0) && (w_data_cnt == '0)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_RUN;
            r_stage_valid <= '0;
        end else begin
            r_state       <= w_state_next;
            r_stage_valid <= w_sv_next;
        end
    end

    out_cnt #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_inst_cnt (
        .clk        (clk),
        .i_resetn   (resetn),
        .i_inc      (inst_req_fire),
        .i_dec      (inst_resp),
        .o_cnt      (w_inst_cnt),
        .o_cnt_next (w_inst_cnt_next),
        .o_err      (w_inst_err)
    );

    out_cnt #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_data_cnt (
        .clk        (clk),
        .i_resetn   (resetn),
        .i_inc      (data_req_fire),
        .i_dec      (data_resp),
        .o_cnt      (w_data_cnt),
        .o_cnt_next (w_data_cnt_next),
        .o_err      (w_data_err)
    );

    // Handshake outputs are forced to their idle values while reset is held.
    assign stage_valid = r_stage_valid;
    assign allowin     = resetn ? w_allowin : '1;
    assign load_en     = resetn ? w_load : '0;
    assign flush       = resetn & w_flush;
    assign fetch_en    = resetn & w_fetch_en;
    assign drop_resp   = resetn & (r_state != ST_RUN) & (inst_resp | data_resp);
    assign state       = r_state;
    assign ovf_err     = w_inst_err | w_data_err;

endmodule
